// File: rtl/vision_pkg.sv
// rtl/vision_pkg.sv - shared types, defaults and saturating helpers for vision_detector
//   vis_state_t      : detector FSM state encoding (3 bits)
//   *_DEF            : default parameter values for vision_detector
//   sat_add10/sub10  : 10-bit add/subtract clamped to 0..1023
package vision_pkg;

   typedef enum logic [2:0] {
      ST_CLEAR     = 3'd0,
      ST_SUSPECT   = 3'd1,
      ST_CAUGHT    = 3'd2,
      ST_COOLDOWN  = 3'd3,
      ST_GAME_OVER = 3'd4
   } vis_state_t;

   localparam int SUSPECT_FRAMES_DEF  = 8;
   localparam int DECAY_FRAMES_DEF    = 2;
   localparam int COOLDOWN_FRAMES_DEF = 60;
   localparam int MAX_CATCHES_DEF     = 3;

   // Sum is formed in 11 bits so the carry shows the overflow to clamp on.
   function automatic logic [9:0] sat_add10(input logic [9:0] a, input logic [9:0] b);
      logic [10:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[10] ? 10'h3FF : s[9:0];
   endfunction

   // Difference is formed in 11 bits so the borrow shows the underflow to clamp on.
   function automatic logic [9:0] sat_sub10(input logic [9:0] a, input logic [9:0] b);
      logic [10:0] d;
      d = {1'b0, a} - {1'b0, b};
      return d[10] ? 10'h000 : d[9:0];
   endfunction

endpackage

// File: rtl/vision_detector_if.sv
// rtl/vision_detector_if.sv - player/vision-window inputs and detector status outputs
//   master : scene/camera side, drives enable, player box and window, reads status
//   slave  : detector side, reads scene, drives in_view, suspicion, caught,
//            cam_hold, catch_count, game_over
interface vision_detector_if;

   logic       enable;
   logic [9:0] playerX;
   logic [9:0] playerY;
   logic [9:0] playerS;
   logic [9:0] vision_startX;
   logic [9:0] vision_endX;
   logic [9:0] vision_startY;
   logic [9:0] vision_endY;

   logic       in_view;
   logic [3:0] suspicion;
   logic       caught;
   logic       cam_hold;
   logic [2:0] catch_count;
   logic       game_over;

   modport master (
      output enable, playerX, playerY, playerS,
             vision_startX, vision_endX, vision_startY, vision_endY,
      input  in_view, suspicion, caught, cam_hold, catch_count, game_over
   );

   modport slave (
      input  enable, playerX, playerY, playerS,
             vision_startX, vision_endX, vision_startY, vision_endY,
      output in_view, suspicion, caught, cam_hold, catch_count, game_over
   );

endinterface

// File: rtl/vision_overlap.sv
// rtl/vision_overlap.sv - combinational player-box versus vision-window overlap test
//   player_x_i/player_y_i : player centre
//   player_s_i            : half-size on both axes
//   win_*_i               : inclusive vision window bounds
//   overlap_o             : 1 when the saturated player box touches the window
module vision_overlap
   import vision_pkg::*;
(
   input  logic [9:0] player_x_i,
   input  logic [9:0] player_y_i,
   input  logic [9:0] player_s_i,
   input  logic [9:0] win_start_x_i,
   input  logic [9:0] win_end_x_i,
   input  logic [9:0] win_start_y_i,
   input  logic [9:0] win_end_y_i,
   output logic       overlap_o
);

   logic [9:0] box_x0;
   logic [9:0] box_x1;
   logic [9:0] box_y0;
   logic [9:0] box_y1;
   logic       hit_x;
   logic       hit_y;

   assign box_x0 = sat_sub10(player_x_i, player_s_i);
   assign box_x1 = sat_add10(player_x_i, player_s_i);
   assign box_y0 = sat_sub10(player_y_i, player_s_i);
   assign box_y1 = sat_add10(player_y_i, player_s_i);

   // An inverted window (camera wrapped below zero) is treated as empty.
   assign hit_x = (win_start_x_i <= win_end_x_i) &&
                  (box_x0 <= win_end_x_i) && (box_x1 >= win_start_x_i);
   assign hit_y = (win_start_y_i <= win_end_y_i) &&
                  (box_y0 <= win_end_y_i) && (box_y1 >= win_start_y_i);

   assign overlap_o = hit_x && hit_y;

endmodule

// File: rtl/vision_detector.sv
// rtl/vision_detector.sv - per-frame suspicion FSM, catch counter and camera hold request
//   frame_clk : frame-rate clock, rising edge
//   Reset     : asynchronous, active-high
//   bus       : vision_detector_if.slave, scene inputs and status outputs
//   VISION_DECAY_EN : when defined, suspicion decays one step per DECAY_FRAMES
//                     out-of-view frames; otherwise one out-of-view frame clears it
module vision_detector
   import vision_pkg::*;
#(
   parameter int SUSPECT_FRAMES  = SUSPECT_FRAMES_DEF,
   parameter int DECAY_FRAMES    = DECAY_FRAMES_DEF,
   parameter int COOLDOWN_FRAMES = COOLDOWN_FRAMES_DEF,
   parameter int MAX_CATCHES     = MAX_CATCHES_DEF
)
(
   input logic               frame_clk,
   input logic               Reset,
   vision_detector_if.slave  bus
);

   localparam logic [3:0] SUSP_LIMIT = 4'(SUSPECT_FRAMES);
   localparam logic [7:0] COOL_LOAD  = 8'(COOLDOWN_FRAMES);
   localparam logic [2:0] CATCH_MAX  = 3'(MAX_CATCHES);
`ifdef VISION_DECAY_EN
   localparam logic [7:0] DECAY_LIMIT = 8'(DECAY_FRAMES);
`else
   localparam int decay_frames_unused = DECAY_FRAMES;
`endif

   vis_state_t state_q;
   logic       in_view_q;
   logic [3:0] suspicion_q;
   logic       caught_q;
   logic       cam_hold_q;
   logic [2:0] catch_count_q;
   logic       game_over_q;
   logic [7:0] timer_q;
`ifdef VISION_DECAY_EN
   logic [7:0] decay_cnt_q;
`endif

   logic       overlap;
   logic       hit;
   logic [3:0] suspicion_inc_d;
   logic [2:0] catch_count_d;

   vision_overlap u_overlap (
      .player_x_i    (bus.playerX),
      .player_y_i    (bus.playerY),
      .player_s_i    (bus.playerS),
      .win_start_x_i (bus.vision_startX),
      .win_end_x_i   (bus.vision_endX),
      .win_start_y_i (bus.vision_startY),
      .win_end_y_i   (bus.vision_endY),
      .overlap_o     (overlap)
   );

   assign hit             = overlap && bus.enable;
   assign suspicion_inc_d = suspicion_q + 4'd1;
   assign catch_count_d   = (catch_count_q == 3'd7) ? 3'd7 : catch_count_q + 3'd1;

   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         state_q       <= ST_CLEAR;
         in_view_q     <= 1'b0;
         suspicion_q   <= 4'd0;
         caught_q      <= 1'b0;
         cam_hold_q    <= 1'b0;
         catch_count_q <= 3'd0;
         game_over_q   <= 1'b0;
         timer_q       <= 8'd0;
`ifdef VISION_DECAY_EN
         decay_cnt_q   <= 8'd0;
`endif
      end else begin
         in_view_q <= hit;
         caught_q  <= 1'b0;
         case (state_q)
            ST_CLEAR: begin
               if (hit) begin
                  suspicion_q <= 4'd1;
`ifdef VISION_DECAY_EN
                  decay_cnt_q <= 8'd0;
`endif
                  // A single in-view frame is already a catch when the limit is 1.
                  if (SUSP_LIMIT == 4'd1) begin
                     state_q       <= ST_CAUGHT;
                     caught_q      <= 1'b1;
                     cam_hold_q    <= 1'b1;
                     catch_count_q <= catch_count_d;
                  end else begin
                     state_q <= ST_SUSPECT;
                  end
               end
            end
            ST_SUSPECT: begin
               if (hit) begin
                  suspicion_q <= suspicion_inc_d;
`ifdef VISION_DECAY_EN
                  decay_cnt_q <= 8'd0;
`endif
                  if (suspicion_inc_d == SUSP_LIMIT) begin
                     state_q       <= ST_CAUGHT;
                     caught_q      <= 1'b1;
                     cam_hold_q    <= 1'b1;
                     catch_count_q <= catch_count_d;
                  end
               end else begin
`ifdef VISION_DECAY_EN
                  if (decay_cnt_q + 8'd1 >= DECAY_LIMIT) begin
                     decay_cnt_q <= 8'd0;
                     suspicion_q <= suspicion_q - 4'd1;
                     if (suspicion_q == 4'd1) begin
                        state_q <= ST_CLEAR;
                     end
                  end else begin
                     decay_cnt_q <= decay_cnt_q + 8'd1;
                  end
`else
                  suspicion_q <= 4'd0;
                  state_q     <= ST_CLEAR;
`endif
               end
            end
            ST_CAUGHT: begin
               if (catch_count_q == CATCH_MAX) begin
                  state_q     <= ST_GAME_OVER;
                  game_over_q <= 1'b1;
               end else begin
                  state_q <= ST_COOLDOWN;
                  timer_q <= COOL_LOAD;
               end
            end
            ST_COOLDOWN: begin
               // Player position is deliberately ignored while the camera is held.
               if (timer_q <= 8'd1) begin
                  state_q     <= ST_CLEAR;
                  timer_q     <= 8'd0;
                  suspicion_q <= 4'd0;
                  cam_hold_q  <= 1'b0;
               end else begin
                  timer_q <= timer_q - 8'd1;
               end
            end
            ST_GAME_OVER: begin
               game_over_q <= 1'b1;
               cam_hold_q  <= 1'b1;
            end
            default: begin
               state_q <= ST_CLEAR;
            end
         endcase
      end
   end

   assign bus.in_view     = in_view_q;
   assign bus.suspicion   = suspicion_q;
   assign bus.caught      = caught_q;
   assign bus.cam_hold    = cam_hold_q;
   assign bus.catch_count = catch_count_q;
   assign bus.game_over   = game_over_q;

endmodule
